// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one 1-bit adder cell stepped over WIDTH-bit operands, LSB first.
// Optional subtract mode enabled by defining SERIAL_SUB_EN (adds the 'sub' port).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH-1:0] res_next;

    // Full adder built from two half adders plus an OR for the carry; returns {carry, sum}.
    function automatic logic [1:0] bit_cell(input logic a, input logic b, input logic c);
        logic h1_s, h1_c, h2_s, h2_c;
        h1_s = a ^ b;
        h1_c = a & b;
        h2_s = h1_s ^ c;
        h2_c = h1_s & c;
        return {h1_c | h2_c, h2_s};
    endfunction

    assign {cell_c, cell_s} = bit_cell(a_sh[0], b_sh[0], carry);

    // After WIDTH-1 shifts res_sh holds the low bits; the final cell output completes the word.
    assign res_next = {cell_s, res_sh};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            C_out <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef SERIAL_SUB_EN
                        // Subtraction as A + ~B + 1: invert B once at capture, seed carry with 1.
                        b_sh  <= sub ? ~B : B;
                        carry <= sub;
`else
                        b_sh  <= B;
                        carry <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    carry  <= cell_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        Sum   <= res_next;
                        C_out <= cell_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): vector table, corner sequences and random ops.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         C_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .C_out (C_out)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the captured operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] sum, output logic cout);
        int unsigned r;
        if (s) begin
            r    = (int'(a) - int'(b)) & ((1 << W) - 1);
            sum  = r[W-1:0];
            cout = (a >= b);
        end else begin
            r    = int'(a) + int'(b);
            sum  = r[W-1:0];
            cout = (r >= (1 << W));
        end
    endtask

    // One operation: start for one cycle, scramble A/B after capture, check latency and result.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] esum, input logic ecout);
        int cyc;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
`ifdef SERIAL_SUB_EN
        sub = s;
`endif
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 4 * W) begin
            A = W'($urandom); B = W'($urandom);
            @(negedge clk);
            cyc++;
        end
        check({name, "_lat"}, cyc, W);
        check({name, "_sum"}, Sum, esum);
        check({name, "_cout"}, C_out, ecout);
        check({name, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check({name, "_done_1cyc"}, done, 0);
    endtask

    vec_t vec[6];
`ifdef SERIAL_SUB_EN
    vec_t svec[3];
`endif

    initial begin
        logic [W-1:0] es;
        logic         ec;
        logic [W-1:0] ra, rb;
        int           ndone;
        int           t_done[2];
        int           cyc;
        logic         held_ok;

        vec[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vec[1] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vec[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vec[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vec[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vec[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
`ifdef SERIAL_SUB_EN
        svec[0] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
        svec[1] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
        svec[2] = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1};
        sub = 1'b0;
`endif

        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", Sum, 0);
        check("rst_cout", C_out, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vec[i].a, vec[i].b, vec[i].s, vec[i].sum, vec[i].cout);
`ifdef SERIAL_SUB_EN
        for (int i = 0; i < 3; i++)
            do_op($sformatf("svec%0d", i), svec[i].a, svec[i].b, svec[i].s, svec[i].sum, svec[i].cout);
`endif

        // start held high through RUN with changing operands: one op on captured values.
        @(negedge clk);
        A = 8'h21; B = 8'h43; start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 3 * W; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("hold_sum", Sum, 8'h64);
                check("hold_cout", C_out, 0);
                start = 1'b0;
            end else if (start) begin
                A = W'($urandom); B = W'($urandom);
            end
        end
        check("hold_one_done", ndone, 1);

        // Reset during the 4th RUN cycle aborts the operation.
        @(negedge clk);
        A = 8'h12; B = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", Sum, 0);
        check("abort_cout", C_out, 0);
        ndone = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Back-to-back with start tied high: done every WIDTH+2 cycles, Sum held during RUN.
        @(negedge clk);
        A = 8'h03; B = 8'h04; start = 1'b1;
        ndone = 0; held_ok = 1'b1;
        t_done[0] = 0; t_done[1] = 0;
        cyc = 0;
        while (ndone < 2 && cyc < 6 * W) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                t_done[ndone] = cyc;
                ndone++;
                if (ndone == 1) begin
                    check("b2b_sum0", Sum, 8'h07);
                    A = 8'h0A; B = 8'h14;
                end else begin
                    check("b2b_sum1", Sum, 8'h1E);
                end
            end else if (ndone == 1 && busy && Sum !== 8'h07) begin
                held_ok = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_count", ndone, 2);
        check("b2b_period", t_done[1] - t_done[0], W + 2);
        check("b2b_sum_held", held_ok, 1);
        repeat (W + 3) @(negedge clk);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            logic s;
            ra = W'($urandom);
            rb = W'($urandom);
            s  = 1'b0;
`ifdef SERIAL_SUB_EN
            s  = 1'($urandom);
`endif
            model(ra, rb, s, es, ec);
            do_op($sformatf("rnd%0d", i), ra, rb, s, es, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
